// File: rtl/mem_word_sequencer.sv
// mem_word_sequencer
// Turns one 32-bit word request (read or write) into a run of byte accesses on
// a byte-wide memory with a level-sensitive write enable. Bytes are little-endian
// at consecutive addresses that wrap modulo 2^ADDR_W. Writes go through a
// setup / strobe / hold cycle per byte, so mem_A and mem_WD are never moved on
// an edge where mem_WE is high before or after that edge.
// Every output is driven by a flop.
module mem_word_sequencer #(
    parameter int ADDR_W = 8,
    parameter int NBYTES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [8*NBYTES-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] rdata,
    output logic [ADDR_W-1:0]   mem_A,
    output logic [7:0]          mem_WD,
    output logic                mem_WE,
    input  logic [7:0]          mem_RD
);
    localparam int WORD_W = 8 * NBYTES;
    localparam int K_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_BYTE   = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_STROBE = 3'd3,
        S_WR_HOLD   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [WORD_W-1:0]   wdata_r;
    logic [WORD_W-1:0]   wdata_nxt_s;
    logic [K_W-1:0]      k_r;
    logic [K_W-1:0]      k_nxt_s;
    logic [K_W-1:0]      k_inc_s;
    logic [ADDR_W-1:0]   next_a_s;
    logic                last_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic [WORD_W-1:0]   rdata_nxt_s;
    logic [ADDR_W-1:0]   mem_a_nxt_s;
    logic [7:0]          mem_wd_nxt_s;
    logic                mem_we_nxt_s;

    // Byte idx of a word, little-endian (byte 0 = bits [7:0]).
    function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] word,
                                           input logic [K_W-1:0]    idx);
        byte_of = word[{idx, 3'b000} +: 8];
    endfunction

    assign last_s   = (k_r == K_LAST);
    assign k_inc_s  = k_r + K_W'(1'b1);
    assign next_a_s = addr_r + ADDR_W'(k_inc_s);

    // State, latched request and all registered outputs; reset aborts at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
            k_r     <= {K_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= {WORD_W{1'b0}};
            mem_A   <= {ADDR_W{1'b0}};
            mem_WD  <= 8'h00;
            mem_WE  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            k_r     <= k_nxt_s;
            busy    <= busy_nxt_s;
            done    <= done_nxt_s;
            rdata   <= rdata_nxt_s;
            mem_A   <= mem_a_nxt_s;
            mem_WD  <= mem_wd_nxt_s;
            mem_WE  <= mem_we_nxt_s;
        end
    end

    // Next-state selection: one cycle per read byte, three per written byte.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = wr ? S_WR_SETUP : S_RD_BYTE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD_BYTE: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RD_BYTE;
                end
            end
            S_WR_SETUP:  state_nxt_s = S_WR_STROBE;
            S_WR_STROBE: state_nxt_s = S_WR_HOLD;
            S_WR_HOLD: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_WR_SETUP;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Next values of the datapath and output flops for the current state.
    always_comb begin
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        k_nxt_s      = k_r;
        rdata_nxt_s  = rdata;
        mem_a_nxt_s  = mem_A;
        mem_wd_nxt_s = mem_WD;
        mem_we_nxt_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    addr_nxt_s  = addr;
                    wdata_nxt_s = wdata;
                    k_nxt_s     = {K_W{1'b0}};
                    mem_a_nxt_s = addr;
                    if (wr) begin
                        mem_wd_nxt_s = wdata[7:0];
                    end else begin
                        mem_wd_nxt_s = mem_WD;
                    end
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            S_RD_BYTE: begin
                // Memory read data is combinational on mem_A; capture it at the edge.
                rdata_nxt_s[{k_r, 3'b000} +: 8] = mem_RD;
                if (!last_s) begin
                    k_nxt_s     = k_inc_s;
                    mem_a_nxt_s = next_a_s;
                end else begin
                    k_nxt_s = k_r;
                end
            end
            S_WR_SETUP:  mem_we_nxt_s = 1'b1;
            S_WR_STROBE: mem_we_nxt_s = 1'b0;
            S_WR_HOLD: begin
                // WE has been low for a full edge, so address and data may move now.
                if (!last_s) begin
                    k_nxt_s      = k_inc_s;
                    mem_a_nxt_s  = next_a_s;
                    mem_wd_nxt_s = byte_of(wdata_r, k_inc_s);
                end else begin
                    k_nxt_s = k_r;
                end
            end
            S_DONE:  mem_we_nxt_s = 1'b0;
            default: mem_we_nxt_s = 1'b0;
        endcase
        busy_nxt_s = (state_nxt_s != S_IDLE);
        done_nxt_s = (state_nxt_s == S_DONE);
    end

endmodule
